// File: rtl/timer_pkg.sv
// timer_pkg: shared time type, state/display enums and lap interval helper for the stopwatch
package timer_pkg;
  typedef logic [19:0] time_t;
  localparam int T_MAX_DEFAULT = 999_999;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD, ST_REVIEW} state_t;
  typedef enum logic [1:0] {LIVE, LAP, REVIEW} disp_src_t;
  // Elapsed time since the previous lap, corrected for the counter wrapping past t_max.
  function automatic time_t lap_interval(time_t now, time_t last, int t_max);
    return now >= last ? now - last : now + time_t'(t_max + 1) - last;
  endfunction
endpackage

// File: rtl/lap_ring.sv
// lap_ring: circular buffer of lap intervals, read by age (0 = newest), saturating count
//   clk     : system clock
//   clr_i   : synchronous clear of pointer and count
//   push_i  : write data_i as the newest entry (overwrites the oldest when full)
//   age_i   : read index counting back from the newest entry
//   data_o  : entry at age_i (combinational)
//   count_o : number of valid entries, saturates at LAP_DEPTH
module lap_ring import timer_pkg::*; #(
  parameter int LAP_DEPTH = 8,
  localparam int AW = $clog2(LAP_DEPTH),
  localparam int CW = $clog2(LAP_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          push_i,
  input  time_t         data_i,
  input  logic [AW-1:0] age_i,
  output time_t         data_o,
  output logic [CW-1:0] count_o
);
  time_t         mem_q [LAP_DEPTH];
  logic [AW-1:0] wr_q;
  logic [CW-1:0] count_q;
  always_ff @(posedge clk) begin
    if (clr_i) begin
      wr_q    <= '0;
      count_q <= '0;
    end else if (push_i) begin
      mem_q[wr_q] <= data_i;
      wr_q        <= wr_q + AW'(1);
      count_q     <= count_q == CW'(LAP_DEPTH) ? count_q : count_q + CW'(1);
    end
  end
  // Power-of-two depth lets the pointer arithmetic wrap naturally.
  assign data_o  = mem_q[wr_q - AW'(1) - age_i];
  assign count_o = count_q;
endmodule

// File: rtl/stopwatch_seq.sv
// stopwatch_seq: run/hold/clear sequencing, lap capture and display source selection
//   clk, KEY2 (sync active-low reset)
//   key_start/key_lap/key_clr : debounced single-cycle key pulses
//   tick_1ms                  : 1 ms strobe, times the lap display window
//   t_now                     : current counter value
//   cnt_en, cnt_clr           : counter enable and one-cycle clear
//   t_disp, disp_src          : displayed value and its source
//   lap_count, lap_idx        : stored laps and review index (0 = newest)
module stopwatch_seq import timer_pkg::*; #(
  parameter int LAP_DEPTH = 8,
  parameter int SHOW_MS   = 3200,
  parameter int T_MAX     = T_MAX_DEFAULT,
  localparam int AW = $clog2(LAP_DEPTH),
  localparam int CW = $clog2(LAP_DEPTH + 1),
  localparam int SW = $clog2(SHOW_MS + 1)
) (
  input  logic          clk,
  input  logic          KEY2,
  input  logic          key_start,
  input  logic          key_lap,
  input  logic          key_clr,
  input  logic          tick_1ms,
  input  time_t         t_now,
  output logic          cnt_en,
  output logic          cnt_clr,
  output time_t         t_disp,
  output disp_src_t     disp_src,
  output logic [CW-1:0] lap_count,
  output logic [AW-1:0] lap_idx
);
  state_t        state_q, state_d;
  disp_src_t     src_q, src_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [SW-1:0] show_q, show_d;
  time_t         last_q, last_d;
  time_t         disp_q, disp_d;
  time_t         ring_data;
  logic          en_q, clr_q;
  logic          k_clr, k_start, k_lap;
  logic          clr_evt, lap_evt, rev_enter, rev_step;
  // Priority decode: a higher-priority key masks the lower ones even if it is ignored in this state.
  assign k_clr   = key_clr;
  assign k_start = key_start & ~key_clr;
  assign k_lap   = key_lap & ~key_start & ~key_clr;
  assign clr_evt   = k_clr && (state_q == ST_HOLD || state_q == ST_REVIEW);
  assign lap_evt   = k_lap && state_q == ST_RUN;
  assign rev_enter = k_lap && state_q == ST_HOLD && lap_count != '0;
  assign rev_step  = k_lap && state_q == ST_REVIEW;
  always_ff @(posedge clk) state_q <= !KEY2 ? ST_IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = k_start ? ST_RUN : ST_IDLE;
      ST_RUN:    state_d = k_start ? ST_HOLD : ST_RUN;
      ST_HOLD:   state_d = clr_evt ? ST_IDLE : k_start ? ST_RUN : rev_enter ? ST_REVIEW : ST_HOLD;
      ST_REVIEW: state_d = clr_evt ? ST_IDLE : k_start ? ST_HOLD : ST_REVIEW;
      default:   state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    src_d  = src_q;
    show_d = show_q;
    idx_d  = idx_q;
    last_d = last_q;
    // The window expires one cycle after the counter has run down to zero.
    if (src_q == LAP) begin
      if (show_q == '0) src_d = LIVE;
      else if (tick_1ms) show_d = show_q - SW'(1);
    end
    if (lap_evt) begin
      src_d  = LAP;
      show_d = SW'(SHOW_MS);
      last_d = t_now;
    end
    if (k_start && (state_q == ST_RUN || state_q == ST_REVIEW)) begin
      src_d  = LIVE;
      show_d = '0;
    end
    if (rev_enter) begin
      src_d = REVIEW;
      idx_d = '0;
    end
    if (rev_step) idx_d = idx_q == AW'(lap_count - CW'(1)) ? '0 : idx_q + AW'(1);
    if (clr_evt) begin
      src_d  = LIVE;
      show_d = '0;
      idx_d  = '0;
      last_d = '0;
    end
  end
  assign disp_d = src_q == LIVE ? t_now : ring_data;
  always_ff @(posedge clk) begin
    if (!KEY2) begin
      src_q  <= LIVE;
      show_q <= '0;
      idx_q  <= '0;
      last_q <= '0;
      disp_q <= '0;
      en_q   <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      src_q  <= src_d;
      show_q <= show_d;
      idx_q  <= idx_d;
      last_q <= last_d;
      disp_q <= disp_d;
      en_q   <= state_d == ST_RUN;
      clr_q  <= clr_evt;
    end
  end
  lap_ring #(.LAP_DEPTH(LAP_DEPTH)) u_ring (
    .clk     (clk),
    .clr_i   (!KEY2 || clr_evt),
    .push_i  (lap_evt),
    .data_i  (lap_interval(t_now, last_q, T_MAX)),
    .age_i   (src_q == REVIEW ? idx_q : '0),
    .data_o  (ring_data),
    .count_o (lap_count)
  );
  assign cnt_en   = en_q;
  assign cnt_clr  = clr_q;
  assign t_disp   = disp_q;
  assign disp_src = src_q;
  assign lap_idx  = idx_q;
endmodule

// File: tb/tb_stopwatch_seq.sv
// tb_stopwatch_seq: directed and random stimulus against a queue-based stopwatch model
module tb_stopwatch_seq;
  import timer_pkg::*;
  localparam int DEPTH = 8;
  localparam int SHOW  = 3200;
  localparam int TMAX  = 999_999;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_REVIEW = 3;
  localparam int D_LIVE = 0, D_LAP = 1, D_REVIEW = 2;
  logic      clk = 1'b0;
  logic      KEY2 = 1'b0, key_start = 1'b0, key_lap = 1'b0, key_clr = 1'b0, tick_1ms = 1'b0;
  time_t     t_now = '0;
  logic      cnt_en, cnt_clr;
  time_t     t_disp;
  disp_src_t disp_src;
  logic [3:0] lap_count;
  logic [2:0] lap_idx;
  int checks = 0, failures = 0;
  int m_state = M_IDLE, m_src = D_LIVE, m_idx = 0, m_show = 0, m_last = 0, m_en = 0, m_clr = 0, m_disp = 0;
  int q[$];
  always #5 clk = ~clk;
  stopwatch_seq #(.LAP_DEPTH(DEPTH), .SHOW_MS(SHOW), .T_MAX(TMAX)) dut (
    .clk(clk), .KEY2(KEY2), .key_start(key_start), .key_lap(key_lap), .key_clr(key_clr),
    .tick_1ms(tick_1ms), .t_now(t_now), .cnt_en(cnt_en), .cnt_clr(cnt_clr), .t_disp(t_disp),
    .disp_src(disp_src), .lap_count(lap_count), .lap_idx(lap_idx)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    int ns = m_state, nsrc = m_src, nidx = m_idx, nshow = m_show, nlast = m_last, nclr = 0, ndisp = 0, age;
    bit c = key_clr, s = key_start && !key_clr, l = key_lap && !key_start && !key_clr;
    if (!KEY2) begin
      ns = M_IDLE; nsrc = D_LIVE; nidx = 0; nshow = 0; nlast = 0;
      q.delete();
    end else begin
      age = m_src == D_REVIEW ? m_idx : 0;
      ndisp = m_src == D_LIVE ? int'(t_now) : (age < q.size() ? q[age] : 0);
      if (m_src == D_LAP) begin
        if (m_show == 0) nsrc = D_LIVE;
        else if (tick_1ms) nshow = m_show - 1;
      end
      case (m_state)
        M_IDLE: if (s) ns = M_RUN;
        M_RUN:
          if (s) begin
            ns = M_HOLD; nsrc = D_LIVE; nshow = 0;
          end else if (l) begin
            q.push_front(int'(t_now) >= m_last ? int'(t_now) - m_last : int'(t_now) + TMAX + 1 - m_last);
            if (q.size() > DEPTH) void'(q.pop_back());
            nlast = int'(t_now); nsrc = D_LAP; nshow = SHOW;
          end
        M_HOLD:
          if (c) begin
            ns = M_IDLE; nclr = 1; q.delete(); nlast = 0; nidx = 0; nsrc = D_LIVE; nshow = 0;
          end else if (s) ns = M_RUN;
          else if (l && q.size() > 0) begin
            ns = M_REVIEW; nidx = 0; nsrc = D_REVIEW;
          end
        default:
          if (c) begin
            ns = M_IDLE; nclr = 1; q.delete(); nlast = 0; nidx = 0; nsrc = D_LIVE; nshow = 0;
          end else if (s) begin
            ns = M_HOLD; nsrc = D_LIVE;
          end else if (l) nidx = (m_idx + 1) % q.size();
      endcase
    end
    @(posedge clk);
    #1;
    m_state = ns; m_src = nsrc; m_idx = nidx; m_show = nshow; m_last = nlast;
    m_en = KEY2 && ns == M_RUN; m_clr = KEY2 ? nclr : 0; m_disp = ndisp;
    check("cnt_en", cnt_en, m_en);
    check("cnt_clr", cnt_clr, m_clr);
    check("t_disp", t_disp, m_disp);
    check("disp_src", disp_src, m_src);
    check("lap_count", lap_count, q.size());
    check("lap_idx", lap_idx, m_idx);
    key_start = 1'b0; key_lap = 1'b0; key_clr = 1'b0;
  endtask
  task automatic lap_at(input int t);
    t_now = time_t'(t); key_lap = 1'b1; step();
  endtask
  initial begin
    KEY2 = 1'b0; step(); step();
    check("rst_disp_src", disp_src, D_LIVE);
    check("rst_t_disp", t_disp, 0);
    KEY2 = 1'b1;
    key_start = 1'b1; step();
    check("start_cnt_en", cnt_en, 1);
    lap_at(1500); step();
    check("lap1500_disp", t_disp, 1500);
    check("lap1500_src", disp_src, D_LAP);
    tick_1ms = 1'b1;
    for (int i = 0; i < SHOW; i++) step();
    check("window_last_lap", disp_src, D_LAP);
    step();
    check("window_end_live", disp_src, D_LIVE);
    tick_1ms = 1'b0;
    key_start = 1'b1; step();
    key_clr = 1'b1; key_start = 1'b1; step();
    check("clr_pulse", cnt_clr, 1);
    check("clr_en_off", cnt_en, 0);
    step();
    check("clr_pulse_end", cnt_clr, 0);
    check("clr_count", lap_count, 0);
    key_start = 1'b1; step();
    lap_at(1000); lap_at(2500); lap_at(2600); step();
    check("three_laps", lap_count, 3);
    check("lap100_disp", t_disp, 100);
    lap_at(999_900); lap_at(50); step();
    check("wrap_interval", t_disp, 150);
    lap_at(100); lap_at(200); lap_at(300); lap_at(400);
    check("ring_saturate", lap_count, 8);
    key_start = 1'b1; step();
    for (int i = 0; i < 9; i++) begin
      key_lap = 1'b1; step();
    end
    step();
    check("review_wrap_idx", lap_idx, 0);
    check("review_src", disp_src, D_REVIEW);
    key_lap = 1'b1; step();
    KEY2 = 1'b0; step();
    check("rst_mid_review_src", disp_src, D_LIVE);
    check("rst_mid_review_cnt", lap_count, 0);
    KEY2 = 1'b1;
    key_start = 1'b1; step();
    lap_at(7000); tick_1ms = 1'b1; step();
    KEY2 = 1'b0; step();
    check("rst_mid_lap_src", disp_src, D_LIVE);
    KEY2 = 1'b1; tick_1ms = 1'b0; step();
    for (int i = 0; i < 4000; i++) begin
      key_start = $urandom_range(0, 9) == 0;
      key_lap   = $urandom_range(0, 4) == 0;
      key_clr   = $urandom_range(0, 11) == 0;
      tick_1ms  = $urandom_range(0, 1) == 1;
      KEY2      = $urandom_range(0, 299) != 0;
      t_now     = time_t'($urandom_range(0, TMAX));
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
